abp_sender_ack_receiver: RTL and testbench
==========================================

ABP_SENDER_ACK_RECEIVER -- requirements
Module: abp_sender_ack_receiver

Sender-side stage consuming the 64-byte ACK frames produced by the receiver-side acknowledgment transmitter; extracts and validates the ACK bit for the sender FSM.

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 64, ACK frame length in bytes (legal range 2..256).
REQ-002 SHALL have ports (clock and reset first):
- aclk  in  1  clock; reset aresetn, asynchronous, active-low; clock aclk.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  ACK stream beat valid.
- s_axis_tready  out  1  beat accept.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tdata  in  8  ACK byte.
- expected_bit  in  1  alternating bit the sender is waiting on.
- ack_valid  out  1  one-cycle pulse: valid ACK frame received.
- ack_bit  out  1  bit0 of last valid frame; held between frames.
- ack_match  out  1  one-cycle pulse: valid frame with ack_bit == expected_bit.
- frame_err  out  1  one-cycle pulse: malformed frame detected.
- err_count  out  16  saturating malformed-frame count.
- busy  out  1  high while a frame is in progress.

Function
REQ-003 SHALL accept a beat on a cycle where s_axis_tvalid and s_axis_tready are both high; no other cycle alters frame state.
REQ-004 SHALL drive s_axis_tready high in every cycle from the first clock edge after aresetn deasserts; the block never back-pressures.
REQ-005 SHALL implement states IDLE, RECV, DISCARD with a byte index counter (0..FRAME_LEN-1).
REQ-006 IDLE: on accepted beat -> index 0 processed per REQ-008/009, state RECV (or IDLE/DISCARD per error rules); busy high from the cycle after acceptance.
REQ-007 RECV: each accepted beat increments index by 1.
REQ-008 Beats at index 0..FRAME_LEN-2 SHALL have tdata == 8'h00 and tlast == 0; tdata != 0 -> error, state DISCARD (or IDLE if tlast==1); tlast == 1 -> error, state IDLE.
REQ-009 Beat at index FRAME_LEN-1 SHALL have tlast == 1 and tdata[7:1] == 0; if so -> valid frame, state IDLE; tdata[7:1] != 0 with tlast -> error, IDLE; tlast == 0 -> error, DISCARD.
REQ-010 DISCARD: drop accepted beats until a beat with tlast == 1, then IDLE; no additional frame_err or err_count increment for the discarded beats.
REQ-011 Each malformed frame SHALL produce exactly one frame_err pulse and one err_count increment, the cycle after the offending beat is accepted.
REQ-012 On valid frame: cycle after final beat accepted, ack_valid = 1, ack_bit = tdata[0] of final beat, ack_match = (tdata[0] == expected_bit sampled on the final-beat acceptance cycle); all pulses low next cycle unless another frame completes.
REQ-013 err_count SHALL saturate at 16'hFFFF, never wrap.
REQ-014 busy SHALL be low in IDLE and high in RECV and DISCARD.
REQ-015 Change of expected_bit mid-frame SHALL have no effect except via sampling per REQ-012.
REQ-016 Back-to-back frames (next frame's first beat the cycle after previous tlast) SHALL be accepted with no idle cycle.
REQ-017 tvalid low gaps mid-frame SHALL not alter index or state.

Reset
REQ-018 On aresetn low, asynchronously: state IDLE, index 0, s_axis_tready 0, ack_valid 0, ack_bit 0, ack_match 0, frame_err 0, err_count 0, busy 0.
REQ-019 Reset mid-frame SHALL discard the partial frame; first beat after release is treated as index 0.

Verification
REQ-020 Valid frame: 63x 8'h00 then 8'h01 with tlast, expected_bit=1 -> ack_valid=1, ack_bit=1, ack_match=1 one cycle after last beat; err_count=0.
REQ-021 Stale ACK: same frame with final 8'h00, expected_bit=1 -> ack_valid=1, ack_bit=0, ack_match=0.
REQ-022 Short frame: tlast at index 10 -> frame_err pulse once, err_count=1, no ack_valid, state IDLE; following valid frame accepted normally.
REQ-023 Long frame: 70 beats, tlast on beat 70 -> one frame_err at index 63, beats 64..69 discarded, err_count=1, no ack_valid.
REQ-024 Nonzero padding 8'h55 at index 5 plus random tvalid gaps -> one frame_err, DISCARD until tlast, busy low afterwards.
REQ-025 aresetn asserted at index 30, released, then valid frame with final 8'h01 -> all outputs 0 during reset, ack_valid with ack_bit=1 after frame.

Source files
------------

// File: rtl/abp_sender_ack_receiver.sv
// Sender-side ACK frame checker: validates fixed-length ACK frames (zero padding,
// final byte carrying the alternating bit) and reports ack/match/error pulses.
module abp_sender_ack_receiver #(
    parameter int FRAME_LEN = 64
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic [7:0]  s_axis_tdata,
    input  logic        expected_bit,
    output logic        ack_valid,
    output logic        ack_bit,
    output logic        ack_match,
    output logic        frame_err,
    output logic [15:0] err_count,
    output logic        busy
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DISCARD
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tready_q;
    logic             ack_valid_q, ack_valid_d;
    logic             ack_bit_q, ack_bit_d;
    logic             ack_match_q, ack_match_d;
    logic             frame_err_q, frame_err_d;
    logic [15:0]      err_count_q, err_count_d;
    logic             busy_q, busy_d;
    logic             beat;
    logic             err;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign beat = s_axis_tvalid && tready_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ack_valid_d = 1'b0;
        ack_bit_d   = ack_bit_q;
        ack_match_d = 1'b0;
        err         = 1'b0;
        if (beat) begin
            case (state_q)
                IDLE, RECV: begin
                    // idx_q is held at 0 in IDLE, so both states share the index rules
                    idx_d = '0;
                    if (idx_q == LAST_IDX) begin
                        if (!s_axis_tlast) begin
                            err     = 1'b1;
                            state_d = DISCARD;
                        end else if (s_axis_tdata[7:1] != 7'd0) begin
                            err     = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ack_valid_d = 1'b1;
                            ack_bit_d   = s_axis_tdata[0];
                            ack_match_d = (s_axis_tdata[0] == expected_bit);
                            state_d     = IDLE;
                        end
                    end else if (s_axis_tdata != 8'h00) begin
                        err     = 1'b1;
                        state_d = s_axis_tlast ? IDLE : DISCARD;
                    end else if (s_axis_tlast) begin
                        err     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = RECV;
                    end
                end
                DISCARD: begin
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
        frame_err_d = err;
        err_count_d = err ? sat_inc16(err_count_q) : err_count_q;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tready_q    <= 1'b0;
            ack_valid_q <= 1'b0;
            ack_bit_q   <= 1'b0;
            ack_match_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= 16'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tready_q    <= 1'b1;
            ack_valid_q <= ack_valid_d;
            ack_bit_q   <= ack_bit_d;
            ack_match_q <= ack_match_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign ack_valid     = ack_valid_q;
    assign ack_bit       = ack_bit_q;
    assign ack_match     = ack_match_q;
    assign frame_err     = frame_err_q;
    assign err_count     = err_count_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_abp_sender_ack_receiver.sv
// Randomized bench for abp_sender_ack_receiver: a frame-level reference model
// pushes expected pulses into a queue, a negedge monitor pops and compares.
module tb_abp_sender_ack_receiver;

    localparam int L = 64;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic [7:0]  tdata = 8'h00;
    logic        expected_bit = 1'b0;
    logic        tready;
    logic        ack_valid;
    logic        ack_bit;
    logic        ack_match;
    logic        frame_err;
    logic [15:0] err_count;
    logic        busy;

    abp_sender_ack_receiver #(.FRAME_LEN(L)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tlast  (tlast),
        .s_axis_tdata  (tdata),
        .expected_bit  (expected_bit),
        .ack_valid     (ack_valid),
        .ack_bit       (ack_bit),
        .ack_match     (ack_match),
        .frame_err     (frame_err),
        .err_count     (err_count),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        bit is_ack;
        bit bitv;
        bit match;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    bit  rand_eb = 1'b0;

    // Reference model: beats seen in the current frame, and whether the frame is already spoiled
    int  m_pos = 0;
    bit  m_bad = 1'b0;
    bit  m_rdy = 1'b0;
    int  m_err = 0;
    bit  m_ackbit = 1'b0;
    ev_t m_ev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_err(input bit last);
        m_ev.is_ack = 1'b0;
        m_ev.bitv   = 1'b0;
        m_ev.match  = 1'b0;
        exp_q.push_back(m_ev);
        if (m_err < 65535) m_err++;
        m_bad = !last;
        m_pos = 0;
    endtask

    always @(posedge aclk) begin
        if (!aresetn) begin
            m_pos = 0;
            m_bad = 1'b0;
            m_rdy = 1'b0;
            m_err = 0;
            m_ackbit = 1'b0;
            exp_q.delete();
        end else begin
            if (tvalid && m_rdy) begin
                if (m_bad) begin
                    if (tlast) m_bad = 1'b0;
                end else if (m_pos == L - 1) begin
                    if (tlast && tdata[7:1] == 7'd0) begin
                        m_ackbit    = tdata[0];
                        m_ev.is_ack = 1'b1;
                        m_ev.bitv   = tdata[0];
                        m_ev.match  = (tdata[0] == expected_bit);
                        exp_q.push_back(m_ev);
                        m_pos = 0;
                    end else begin
                        model_err(tlast);
                    end
                end else if (tdata != 8'h00 || tlast) begin
                    model_err(tlast);
                end else begin
                    m_pos++;
                end
            end
            m_rdy = 1'b1;
        end
    end

    always @(negedge aclk) begin
        ev_t e;
        if (!aresetn) begin
            chk("reset_outputs", {10'd0, tready, ack_valid, ack_bit, ack_match, frame_err, busy, err_count}, 32'd0);
            exp_q.delete();
        end else begin
            chk("tready", {31'd0, tready}, {31'd0, m_rdy});
            chk("busy", {31'd0, busy}, {31'd0, (m_pos != 0) || m_bad});
            chk("err_count", {16'd0, err_count}, m_err);
            chk("ack_bit", {31'd0, ack_bit}, {31'd0, m_ackbit});
            if (ack_valid || frame_err || exp_q.size() > 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, ack_valid, frame_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulses", {29'd0, ack_valid, frame_err, ack_match},
                        {29'd0, e.is_ack, !e.is_ack, e.is_ack && e.match});
                    if (e.is_ack) chk("ack_bit_on_pulse", {31'd0, ack_bit}, {31'd0, e.bitv});
                end
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
        if (rand_eb) expected_bit = 1'($urandom);
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input int gap_pct);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        step();
        tvalid = 1'b0;
        tdata  = 8'($urandom);
        tlast  = 1'($urandom);
        while ($urandom_range(99) < gap_pct) step();
    endtask

    task automatic frame(input int len, input logic [7:0] fin, input int bad_idx,
                         input logic [7:0] bad_val, input int gap_pct);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            if (i == len - 1) d = fin;
            else if (i == bad_idx) d = bad_val;
            else d = 8'h00;
            beat(d, (i == len - 1), gap_pct);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        int bidx;
        logic [7:0] fin;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        step();
        step();
        expected_bit = 1'b1;
        frame(L, 8'h01, -1, 8'h00, 0);
        frame(L, 8'h00, -1, 8'h00, 0);
        frame(11, 8'h00, -1, 8'h00, 0);
        frame(L, 8'h01, -1, 8'h00, 0);
        frame(70, 8'h00, -1, 8'h00, 0);
        frame(L, 8'h01, 5, 8'h55, 30);
        frame(L, 8'h81, -1, 8'h00, 10);
        frame(1, 8'h00, -1, 8'h00, 0);
        repeat (3) step();
        for (int i = 0; i < 30; i++) beat(8'h00, 1'b0, 0);
        aresetn = 1'b0;
        repeat (3) step();
        aresetn = 1'b1;
        step();
        expected_bit = 1'b1;
        frame(L, 8'h01, -1, 8'h00, 0);
        rand_eb = 1'b1;
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(3))
                0: len = $urandom_range(1, 70);
                default: len = L;
            endcase
            bidx = ($urandom_range(3) == 0) ? int'($urandom_range(L - 1)) : -1;
            fin  = ($urandom_range(4) == 0) ? 8'($urandom) : {7'd0, 1'($urandom)};
            frame(len, fin, bidx, 8'($urandom_range(255, 1)), $urandom_range(30));
        end
        repeat (5) step();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
